// File: rtl/dma_flr_pkg.sv
// Shared types and constants for the PCIe Function Level Reset sequencer.
//   flr_state_e    : sequencer FSM state encoding
//   FLR_*_DEF      : default sizing for function count and function-number width
//   FLR_TMO_W      : width of the quiesce timeout counter
//   flr_wrap_inc   : increment an index, wrapping at n-1 -> 0
package dma_flr_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_CMP,
      DONE
   } flr_state_e;

   localparam int unsigned FLR_NUM_FUNC_DEF = 256;
   localparam int unsigned FLR_FNUM_W_DEF   = 8;
   localparam int unsigned FLR_TMO_W        = 16;

   localparam logic [FLR_TMO_W-1:0] FLR_QUIESCE_TMO_DEF = 16'hFFFF;

   function automatic int unsigned flr_wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/dma_pcie_misc_input_if.sv
// Miscellaneous status from the PCIe core consumed by DMA-side logic.
//   cfg2axi_flr_in_progress : per-function FLR-in-progress level
//   cfg_phy_link_down       : physical link down
//   cfg_hot_reset_out       : hot reset received
// Modports: m drives the signals (PCIe core side), s samples them.
interface dma_pcie_misc_input_if #(
   parameter int unsigned NUM_FUNC = 256
);

   logic [NUM_FUNC-1:0] cfg2axi_flr_in_progress;
   logic                cfg_phy_link_down;
   logic                cfg_hot_reset_out;

   modport m (
      output cfg2axi_flr_in_progress,
      output cfg_phy_link_down,
      output cfg_hot_reset_out
   );

   modport s (
      input cfg2axi_flr_in_progress,
      input cfg_phy_link_down,
      input cfg_hot_reset_out
   );

endinterface

// File: rtl/dma_flr_rr_pick.sv
// Combinational round-robin find-first-set.
//   req_i   : NUM_FUNC-bit request vector
//   ptr_i   : round-robin start index (searched first, wrapping to 0)
//   found_o : any request bit set
//   idx_o   : index of the selected request
module dma_flr_rr_pick #(
   parameter int unsigned NUM_FUNC = 256,
   parameter int unsigned FNUM_W   = $clog2(NUM_FUNC)
) (
   input  logic [NUM_FUNC-1:0] req_i,
   input  logic [FNUM_W-1:0]   ptr_i,
   output logic                found_o,
   output logic [FNUM_W-1:0]   idx_o
);

   logic [NUM_FUNC-1:0]   masked;
   logic [2*NUM_FUNC-1:0] dbl;
   logic                  hit;

   // Lower half holds only bits at/after the pointer, upper half the full
   // vector, so a plain lowest-bit-first scan yields the wrapped round-robin
   // choice.
   always_comb begin
      for (int unsigned j = 0; j < NUM_FUNC; j++) begin
         masked[j] = req_i[j] && (j >= 32'(ptr_i));
      end
      dbl = {req_i, masked};
      hit   = 1'b0;
      idx_o = '0;
      for (int unsigned i = 0; i < 2*NUM_FUNC; i++) begin
         if (!hit && dbl[i]) begin
            hit   = 1'b1;
            idx_o = FNUM_W'((i >= NUM_FUNC) ? i - NUM_FUNC : i);
         end
      end
      found_o = hit;
   end

endmodule

// File: rtl/dma_pcie_flr_sequencer.sv
// Sequences PCIe Function Level Resets one at a time.
// Newly started FLRs (rising cfg2axi_flr_in_progress bits) are queued in a
// pending vector, served round-robin, handed to the DMA quiesce logic over
// flr_req (valid/ready), and acknowledged to the PCIe core with a one-cycle
// cfg_flr_done pulse once the DMA reports completion or the quiesce times out.
//   user_clk, user_reset          : clock, synchronous active-high reset
//   misc_in                       : FLR status, link-down and hot-reset inputs
//   flr_req_vld/_fnum/_rdy        : quiesce request to DMA
//   flr_cmp_vld/_fnum             : quiesce completion from DMA
//   cfg_flr_done/_fnum            : FLR completion pulse to PCIe core
//   flr_busy                      : FSM active or FLRs pending
//   flr_tmo_err                   : pulse on quiesce timeout
//   flr_abort                     : pulse when link-down/hot-reset flushes work
module dma_pcie_flr_sequencer
   import dma_flr_pkg::*;
#(
   parameter int unsigned           NUM_FUNC    = FLR_NUM_FUNC_DEF,
   parameter int unsigned           FNUM_W      = $clog2(NUM_FUNC),
   parameter logic [FLR_TMO_W-1:0]  QUIESCE_TMO = FLR_QUIESCE_TMO_DEF
) (
   input  logic                user_clk,
   input  logic                user_reset,
   dma_pcie_misc_input_if.s    misc_in,
   output logic                flr_req_vld,
   output logic [FNUM_W-1:0]   flr_req_fnum,
   input  logic                flr_req_rdy,
   input  logic                flr_cmp_vld,
   input  logic [FNUM_W-1:0]   flr_cmp_fnum,
   output logic                cfg_flr_done,
   output logic [FNUM_W-1:0]   cfg_flr_done_fnum,
   output logic                flr_busy,
   output logic                flr_tmo_err,
   output logic                flr_abort
);

   localparam logic [FLR_TMO_W-1:0] TMO_LAST = QUIESCE_TMO - 1'b1;

   flr_state_e            state_q, state_d;
   logic [NUM_FUNC-1:0]   flr_q;
   logic [NUM_FUNC-1:0]   pending_q, pending_d;
   logic [NUM_FUNC-1:0]   rise, fall, pick_mask;
   logic [FNUM_W-1:0]     fnum_q, fnum_d;
   logic [FNUM_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [FLR_TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic                  abort_seen_q, flr_abort_q;
   logic                  abort_now, cmp_match;
   logic                  pick_found;
   logic [FNUM_W-1:0]     pick_idx;
   logic                  req_vld, done_pls, tmo_pls;

   dma_flr_rr_pick #(
      .NUM_FUNC (NUM_FUNC),
      .FNUM_W   (FNUM_W)
   ) u_rr_pick (
      .req_i   (pending_q),
      .ptr_i   (rr_ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   always_comb begin
      abort_now = misc_in.cfg_phy_link_down | misc_in.cfg_hot_reset_out;
      rise      = abort_now ? '0 : (misc_in.cfg2axi_flr_in_progress & ~flr_q);
      fall      = ~misc_in.cfg2axi_flr_in_progress & flr_q;
      cmp_match = flr_cmp_vld && (flr_cmp_fnum == fnum_q);
   end

   always_comb begin
      state_d   = state_q;
      fnum_d    = fnum_q;
      rr_ptr_d  = rr_ptr_q;
      tmo_cnt_d = tmo_cnt_q;
      pick_mask = '0;
      req_vld   = 1'b0;
      done_pls  = 1'b0;
      tmo_pls   = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick_found) begin
               fnum_d              = pick_idx;
               pick_mask[pick_idx] = 1'b1;
               rr_ptr_d            = FNUM_W'(flr_wrap_inc(32'(pick_idx), NUM_FUNC));
               state_d             = REQ;
            end
         end
         REQ: begin
            req_vld = 1'b1;
            if (flr_req_rdy) begin
               tmo_cnt_d = '0;
               state_d   = WAIT_CMP;
            end
         end
         WAIT_CMP: begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (cmp_match) begin
               state_d = DONE;
            end else if (tmo_cnt_q == TMO_LAST) begin
               tmo_pls = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            done_pls = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A picked bit was set earlier, so its input is already high and no
      // rise can target it in the same cycle.
      pending_d = (pending_q & ~fall & ~pick_mask) | rise;

      // Abort overrides everything decided above, including this cycle's
      // handshake and pulse outputs.
      if (abort_now) begin
         state_d   = IDLE;
         pending_d = '0;
         tmo_cnt_d = '0;
         req_vld   = 1'b0;
         done_pls  = 1'b0;
         tmo_pls   = 1'b0;
      end
   end

   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         state_q      <= IDLE;
         flr_q        <= '0;
         pending_q    <= '0;
         fnum_q       <= '0;
         rr_ptr_q     <= '0;
         tmo_cnt_q    <= '0;
         abort_seen_q <= 1'b0;
         flr_abort_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         flr_q        <= misc_in.cfg2axi_flr_in_progress;
         pending_q    <= pending_d;
         fnum_q       <= fnum_d;
         rr_ptr_q     <= rr_ptr_d;
         tmo_cnt_q    <= tmo_cnt_d;
         abort_seen_q <= abort_now;
         flr_abort_q  <= abort_now & ~abort_seen_q;
      end
   end

   always_comb begin
      flr_req_vld       = req_vld;
      flr_req_fnum      = req_vld ? fnum_q : '0;
      cfg_flr_done      = done_pls;
      cfg_flr_done_fnum = done_pls ? fnum_q : '0;
      flr_tmo_err       = tmo_pls;
      flr_abort         = flr_abort_q;
      flr_busy          = (state_q != IDLE) || (|pending_q);
   end

endmodule

// File: tb/tb_dma_pcie_flr_sequencer.sv
// Directed self-checking bench for dma_pcie_flr_sequencer.
// Inputs change and outputs are sampled just after the falling clock edge.
module tb_dma_pcie_flr_sequencer;

   localparam int unsigned NF = 256;
   localparam int unsigned FW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          rdy;
   logic          cmp_vld;
   logic [FW-1:0] cmp_fnum;
   logic          req_vld;
   logic [FW-1:0] req_fnum;
   logic          done;
   logic [FW-1:0] done_fnum;
   logic          busy;
   logic          tmo_err;
   logic          abort;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   dma_pcie_misc_input_if #(.NUM_FUNC(NF)) misc_if ();

   dma_pcie_flr_sequencer #(
      .NUM_FUNC    (NF),
      .FNUM_W      (FW),
      .QUIESCE_TMO (16'd16)
   ) dut (
      .user_clk          (clk),
      .user_reset        (rst),
      .misc_in           (misc_if),
      .flr_req_vld       (req_vld),
      .flr_req_fnum      (req_fnum),
      .flr_req_rdy       (rdy),
      .flr_cmp_vld       (cmp_vld),
      .flr_cmp_fnum      (cmp_fnum),
      .cfg_flr_done      (done),
      .cfg_flr_done_fnum (done_fnum),
      .flr_busy          (busy),
      .flr_tmo_err       (tmo_err),
      .flr_abort         (abort)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_bit(input int unsigned b, input logic v);
      misc_if.cfg2axi_flr_in_progress[b] = v;
   endtask

   // Called in a REQ cycle with rdy=1: accept, complete on the first
   // WAIT_CMP cycle, check the done pulse, end in the following IDLE cycle.
   task automatic serve(input string tag, input logic [FW-1:0] f);
      chk({tag, "_vld"}, 32'(req_vld), 32'd1);
      chk({tag, "_fnum"}, 32'(req_fnum), 32'(f));
      tick();
      cmp_vld  = 1'b1;
      cmp_fnum = f;
      tick();
      cmp_vld = 1'b0;
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_done_fnum"}, 32'(done_fnum), 32'(f));
      tick();
      chk({tag, "_done_off"}, 32'(done), 32'd0);
      chk({tag, "_gap_vld"}, 32'(req_vld), 32'd0);
   endtask

   initial begin
      rst      = 1'b1;
      rdy      = 1'b1;
      cmp_vld  = 1'b0;
      cmp_fnum = '0;
      misc_if.cfg2axi_flr_in_progress = '0;
      misc_if.cfg_phy_link_down       = 1'b0;
      misc_if.cfg_hot_reset_out       = 1'b0;
      repeat (3) tick();

      // Reset state
      chk("rst_vld",   32'(req_vld), 32'd0);
      chk("rst_fnum",  32'(req_fnum), 32'd0);
      chk("rst_done",  32'(done), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_tmo",   32'(tmo_err), 32'd0);
      chk("rst_abort", 32'(abort), 32'd0);
      rst = 1'b0;
      tick();

      // 1: single FLR, request two cycles after rise, completion 3 cycles after accept
      set_bit(5, 1'b1);
      tick();
      chk("t1_vld_n1",  32'(req_vld), 32'd0);
      chk("t1_busy_n1", 32'(busy), 32'd1);
      tick();
      chk("t1_vld_n2",  32'(req_vld), 32'd1);
      chk("t1_fnum_n2", 32'(req_fnum), 32'd5);
      tick();
      chk("t1_vld_wait", 32'(req_vld), 32'd0);
      tick();
      tick();
      cmp_vld  = 1'b1;
      cmp_fnum = 8'd5;
      tick();
      cmp_vld = 1'b0;
      chk("t1_done",      32'(done), 32'd1);
      chk("t1_done_fnum", 32'(done_fnum), 32'd5);
      chk("t1_tmo",       32'(tmo_err), 32'd0);
      tick();
      chk("t1_done_off", 32'(done), 32'd0);
      chk("t1_idle",     32'(busy), 32'd0);
      set_bit(5, 1'b0);

      // 2: round-robin order from pointer 0, then wrap from pointer 201
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      set_bit(3, 1'b1);
      set_bit(200, 1'b1);
      tick();
      tick();
      serve("t2_f3", 8'd3);
      tick();
      serve("t2_f200", 8'd200);
      set_bit(3, 1'b0);
      set_bit(200, 1'b0);
      tick();
      set_bit(3, 1'b1);
      set_bit(4, 1'b1);
      tick();
      tick();
      serve("t2_wrap3", 8'd3);
      tick();
      serve("t2_wrap4", 8'd4);
      set_bit(3, 1'b0);
      set_bit(4, 1'b0);

      // 3: timeout (QUIESCE_TMO=16): tmo_err on the 16th cycle after accept, done on the next
      set_bit(20, 1'b1);
      tick();
      tick();
      chk("t3_vld",  32'(req_vld), 32'd1);
      chk("t3_fnum", 32'(req_fnum), 32'd20);
      for (int i = 1; i <= 15; i++) begin
         tick();
         chk("t3_tmo_early", 32'(tmo_err | done), 32'd0);
      end
      tick();
      chk("t3_tmo",      32'(tmo_err), 32'd1);
      chk("t3_done_pre", 32'(done), 32'd0);
      tick();
      chk("t3_done",      32'(done), 32'd1);
      chk("t3_done_fnum", 32'(done_fnum), 32'd20);
      chk("t3_tmo_off",   32'(tmo_err), 32'd0);
      tick();
      set_bit(20, 1'b0);

      // 4: completion for another function is ignored
      set_bit(7, 1'b1);
      tick();
      tick();
      chk("t4_fnum", 32'(req_fnum), 32'd7);
      tick();
      cmp_vld  = 1'b1;
      cmp_fnum = 8'd9;
      tick();
      cmp_vld = 1'b0;
      chk("t4_ignored", 32'(done), 32'd0);
      chk("t4_busy",    32'(busy), 32'd1);
      cmp_vld  = 1'b1;
      cmp_fnum = 8'd7;
      tick();
      cmp_vld = 1'b0;
      chk("t4_done",      32'(done), 32'd1);
      chk("t4_done_fnum", 32'(done_fnum), 32'd7);
      tick();
      set_bit(7, 1'b0);

      // 5: bit 10 rises and falls while another FLR is in service
      set_bit(30, 1'b1);
      tick();
      tick();
      chk("t5_fnum", 32'(req_fnum), 32'd30);
      tick();
      set_bit(10, 1'b1);
      tick();
      set_bit(10, 1'b0);
      tick();
      cmp_vld  = 1'b1;
      cmp_fnum = 8'd30;
      tick();
      cmp_vld = 1'b0;
      chk("t5_done_fnum", 32'(done_fnum), 32'd30);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t5_no_req10", 32'(req_vld), 32'd0);
      end
      chk("t5_idle", 32'(busy), 32'd0);
      set_bit(30, 1'b0);

      // 7: request held stable while rdy is low
      rdy = 1'b0;
      set_bit(40, 1'b1);
      tick();
      tick();
      for (int i = 0; i < 20; i++) begin
         chk("t7_hold_vld",  32'(req_vld), 32'd1);
         chk("t7_hold_fnum", 32'(req_fnum), 32'd40);
         tick();
      end
      rdy = 1'b1;
      serve("t7_f40", 8'd40);
      set_bit(40, 1'b0);

      // 6: hot reset during WAIT_CMP with three FLRs still pending
      set_bit(50, 1'b1);
      set_bit(60, 1'b1);
      set_bit(70, 1'b1);
      set_bit(80, 1'b1);
      tick();
      tick();
      chk("t6_fnum", 32'(req_fnum), 32'd50);
      tick();
      misc_if.cfg_hot_reset_out = 1'b1;
      set_bit(90, 1'b1);
      tick();
      chk("t6_abort", 32'(abort), 32'd1);
      chk("t6_busy",  32'(busy), 32'd0);
      chk("t6_vld",   32'(req_vld), 32'd0);
      tick();
      chk("t6_abort_once", 32'(abort), 32'd0);
      misc_if.cfg_hot_reset_out = 1'b0;
      cmp_vld  = 1'b1;
      cmp_fnum = 8'd50;
      tick();
      cmp_vld = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("t6_no_done", 32'(done), 32'd0);
         chk("t6_no_req",  32'(req_vld), 32'd0);
         tick();
      end
      chk("t6_idle", 32'(busy), 32'd0);

      // Link-down held for several cycles pulses abort only once
      misc_if.cfg_phy_link_down = 1'b1;
      tick();
      chk("ld_abort", 32'(abort), 32'd1);
      tick();
      chk("ld_abort_once", 32'(abort), 32'd0);
      misc_if.cfg_phy_link_down = 1'b0;
      tick();
      chk("ld_abort_off", 32'(abort), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
